// File: rtl/clarke_pkg.sv
// Shared constants, coefficient helper and FSM encoding for the Clarke transform.
// Coefficients are Q1.(COEF_W-1) values of sqrt(2/3), sqrt(1/6) and sqrt(1/2).
package clarke_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MUL_A,
    MUL_B,
    MUL_H,
    HOLD
  } state_e;

  localparam real SQRT_2_3 = 0.816496580927726;
  localparam real SQRT_1_6 = 0.408248290463863;
  localparam real SQRT_1_2 = 0.707106781186548;

  localparam logic [31:0] K_A_16 = 32'h0000_6882;
  localparam logic [31:0] K_B_16 = 32'h0000_3441;
  localparam logic [31:0] K_H_16 = 32'h0000_5A82;

  function automatic logic [31:0] coef(
    input real x,
    input int  cw
  );
    real s;
    s = 1.0;
    for (int i = 1; i < cw; i++) begin
      s = s * 2.0;
    end
    return 32'($rtoi(x * s + 0.5));
  endfunction

endpackage

// File: rtl/clarke_sat.sv
// Floor shift of a wide accumulator down to an OUT_W result.
// CLARKE_SAT_EN selects clamping with a sat flag; otherwise the result wraps.
module clarke_sat
  import clarke_pkg::*;
#(
  parameter int IN_W  = 35,
  parameter int OUT_W = 16,
  parameter int SHIFT = 16
) (
  input  logic signed [IN_W-1:0]  acc_i,
  output logic signed [OUT_W-1:0] res_o,
  output logic                    sat_o
);

  logic signed [IN_W-1:0] shifted;

  assign shifted = acc_i >>> SHIFT;

`ifdef CLARKE_SAT_EN
  logic [IN_W-OUT_W:0] hi;
  logic                ovf;

  assign hi  = shifted[IN_W-1:OUT_W-1];
  // In range only when every bit above the result sign matches it
  assign ovf = !((&hi) || (~|hi));

  always_comb begin
    res_o = shifted[OUT_W-1:0];
    sat_o = 1'b0;
    if (ovf) begin
      sat_o = 1'b1;
      if (shifted[IN_W-1]) begin
        res_o = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        res_o = {1'b0, {(OUT_W-1){1'b1}}};
      end
    end
  end
`else
  logic unused_hi;

  assign unused_hi = ^shifted[IN_W-1:OUT_W];
  assign res_o     = shifted[OUT_W-1:0];
  assign sat_o     = 1'b0;
`endif

endmodule

// File: rtl/clarke_transform_seq.sv
// Sequential power-invariant Clarke transform on one shared signed multiplier.
// Build with CLARKE_SAT_EN defined to clamp overflowing results and flag sat.
module clarke_transform_seq
  import clarke_pkg::*;
#(
  parameter int W      = 16,
  parameter int COEF_W = 16,
  parameter int TWO_PH = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  input  logic signed [W-1:0] i_c,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] i_alpha,
  output logic signed [W-1:0] i_beta,
  output logic                sat
);

  localparam int AW = W + COEF_W + 3;
  localparam int PW = W + 2 + COEF_W;

  localparam logic [31:0] KA_F =
    (COEF_W == 16) ? K_A_16 : coef(SQRT_2_3, COEF_W);
  localparam logic [31:0] KB_F =
    (COEF_W == 16) ? K_B_16 : coef(SQRT_1_6, COEF_W);
  localparam logic [31:0] KH_F =
    (COEF_W == 16) ? K_H_16 : coef(SQRT_1_2, COEF_W);

  localparam logic signed [COEF_W-1:0] KA = KA_F[COEF_W-1:0];
  localparam logic signed [COEF_W-1:0] KB = KB_F[COEF_W-1:0];
  localparam logic signed [COEF_W-1:0] KH = KH_F[COEF_W-1:0];

  state_e state_q;

  logic signed [W:0]    a_q;
  logic signed [W:0]    b_q;
  logic signed [W:0]    c_q;
  logic signed [AW-1:0] acc_alpha_q;
  logic signed [AW-1:0] acc_alpha_d;
  logic signed [AW-1:0] acc_beta_q;
  logic signed [AW-1:0] acc_beta_d;
  logic                 out_valid_q;
  logic signed [W-1:0]  alpha_q;
  logic signed [W-1:0]  beta_q;
  logic                 sat_q;

  logic signed [W:0] a_in;
  logic signed [W:0] b_in;
  logic signed [W:0] c_in;

  assign a_in = {i_a[W-1], i_a};
  assign b_in = {i_b[W-1], i_b};

  generate
    if (TWO_PH != 0) begin : g_two_ph
      logic unused_c;
      assign unused_c = ^i_c;
      assign c_in     = -(a_in + b_in);
    end else begin : g_three_ph
      assign c_in = {i_c[W-1], i_c};
    end
  endgenerate

  logic signed [W+1:0]     mul_x;
  logic signed [COEF_W-1:0] mul_k;
  logic signed [PW-1:0]    prod;
  logic signed [AW-1:0]    prod_x;

  always_comb begin
    mul_x = '0;
    mul_k = '0;
    unique case (state_q)
      MUL_A: begin
        mul_x = {a_q[W], a_q};
        mul_k = KA;
      end
      MUL_B: begin
        mul_x = {b_q[W], b_q} + {c_q[W], c_q};
        mul_k = KB;
      end
      MUL_H: begin
        mul_x = {b_q[W], b_q} - {c_q[W], c_q};
        mul_k = KH;
      end
      default: begin
        mul_x = '0;
        mul_k = '0;
      end
    endcase
  end

  assign prod   = PW'(mul_x) * PW'(mul_k);
  assign prod_x = AW'(prod);

  always_comb begin
    acc_alpha_d = acc_alpha_q;
    acc_beta_d  = acc_beta_q;
    unique case (state_q)
      MUL_A:   acc_alpha_d = prod_x;
      MUL_B:   acc_alpha_d = acc_alpha_q - prod_x;
      MUL_H:   acc_beta_d  = prod_x;
      default: acc_alpha_d = acc_alpha_q;
    endcase
  end

  logic signed [W-1:0] alpha_r;
  logic signed [W-1:0] beta_r;
  logic                sat_a;
  logic                sat_b;

  clarke_sat #(
    .IN_W  (AW),
    .OUT_W (W),
    .SHIFT (COEF_W)
  ) u_sat_alpha (
    .acc_i (acc_alpha_q),
    .res_o (alpha_r),
    .sat_o (sat_a)
  );

  // Beta is formatted straight from the MUL_H product so it lands with alpha
  clarke_sat #(
    .IN_W  (AW),
    .OUT_W (W),
    .SHIFT (COEF_W)
  ) u_sat_beta (
    .acc_i (acc_beta_d),
    .res_o (beta_r),
    .sat_o (sat_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      acc_alpha_q <= '0;
      acc_beta_q  <= '0;
      out_valid_q <= 1'b0;
      alpha_q     <= '0;
      beta_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q         <= a_in;
            b_q         <= b_in;
            c_q         <= c_in;
            acc_alpha_q <= '0;
            acc_beta_q  <= '0;
            state_q     <= MUL_A;
          end
        end
        MUL_A: begin
          acc_alpha_q <= acc_alpha_d;
          state_q     <= MUL_B;
        end
        MUL_B: begin
          acc_alpha_q <= acc_alpha_d;
          state_q     <= MUL_H;
        end
        MUL_H: begin
          acc_beta_q  <= acc_beta_d;
          alpha_q     <= alpha_r;
          beta_q      <= beta_r;
          sat_q       <= sat_a | sat_b;
          out_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = rst_n & (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign i_alpha   = alpha_q;
  assign i_beta    = beta_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_clarke_transform_seq.sv
// Directed and scoreboard bench for clarke_transform_seq.
// Honours CLARKE_SAT_EN when computing expected overflow behaviour.
module tb_clarke_transform_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic               in_valid0, in_ready0, out_valid0, out_ready0, sat0;
  logic signed [15:0] i_a0, i_b0, i_c0, i_alpha0, i_beta0;
  logic               in_valid1, in_ready1, out_valid1, out_ready1, sat1;
  logic signed [15:0] i_a1, i_b1, i_c1, i_alpha1, i_beta1;

  clarke_transform_seq #(.W(16), .COEF_W(16), .TWO_PH(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid0),
    .in_ready  (in_ready0),
    .i_a       (i_a0),
    .i_b       (i_b0),
    .i_c       (i_c0),
    .out_valid (out_valid0),
    .out_ready (out_ready0),
    .i_alpha   (i_alpha0),
    .i_beta    (i_beta0),
    .sat       (sat0)
  );

  clarke_transform_seq #(.W(16), .COEF_W(16), .TWO_PH(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .i_a       (i_a1),
    .i_b       (i_b1),
    .i_c       (i_c1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .i_alpha   (i_alpha1),
    .i_beta    (i_beta1),
    .sat       (sat1)
  );

  typedef struct {
    logic signed [15:0] al;
    logic signed [15:0] be;
    logic               s;
  } res_t;

  res_t q0[$];
  res_t q1[$];
  res_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [15:0] fit(input longint v, output logic s);
    logic signed [15:0] r;
    s = 1'b0;
    r = v[15:0];
`ifdef CLARKE_SAT_EN
    if (v > 32767) begin
      s = 1'b1;
      r = 16'sd32767;
    end else if (v < -32768) begin
      s = 1'b1;
      r = -16'sd32768;
    end
`endif
    return r;
  endfunction

  function automatic res_t model(input int a, input int b, input int c,
                                 input bit two);
    longint cc, al, be;
    logic   s1, s2;
    res_t   r;
    cc   = two ? -(longint'(a) + longint'(b)) : longint'(c);
    al   = (26754 * longint'(a) - 13377 * (longint'(b) + cc)) >>> 16;
    be   = (23170 * (longint'(b) - cc)) >>> 16;
    r.al = fit(al, s1);
    r.be = fit(be, s2);
    r.s  = s1 | s2;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid0 && out_ready0) begin
      if (q0.size() == 0) begin
        chk("unexpected_out", out_valid0, 0);
      end else begin
        mon_e = q0.pop_front();
        chk("alpha", i_alpha0, mon_e.al);
        chk("beta", i_beta0, mon_e.be);
        chk("sat", sat0, mon_e.s);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input int a, input int b, input int c,
                       input bit keep, output int t);
    int n;
    i_a0      = 16'(a);
    i_b0      = 16'(b);
    i_c0      = 16'(c);
    in_valid0 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready0) chk("in_ready_wait", in_ready0, 1);
    @(posedge clk);
    q0.push_back(model(a, b, c, 1'b0));
    #1;
    t = cyc;
    if (!keep) in_valid0 = 1'b0;
  endtask

  task automatic wait_valid0(output int n);
    n = 0;
    while (!out_valid0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid0) chk("out_valid_wait", out_valid0, 1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q0.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q0.size(), 0);
  endtask

  initial begin
    int   n, t, t_prev, a, b, c;
    res_t bp_e, e1;

    in_valid0 = 0; out_ready0 = 1; i_a0 = 0; i_b0 = 0; i_c0 = 0;
    in_valid1 = 0; out_ready1 = 1; i_a1 = 0; i_b1 = 0; i_c1 = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_alpha", i_alpha0, 0);
    chk("rst_beta", i_beta0, 0);
    chk("rst_sat", sat0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    send0(16384, -8192, -8192, 1'b0, t);
    wait_valid0(n);
    chk("latency", n - 1, 3);
    chk("t1_alpha_ref", i_alpha0, 10032);
    chk("t1_beta_ref", i_beta0, 0);

    step();
    send0(0, 10000, -10000, 1'b0, t);
    wait_valid0(n);
    chk("t2_alpha_ref", i_alpha0, 0);
    chk("t2_beta_ref", i_beta0, 7070);
    wait_drain();

    step();
    i_a1 = 16'sd32767; i_b1 = 16'sd32767; i_c1 = 16'sd12345;
    in_valid1 = 1'b1;
    @(posedge clk);
    q1.push_back(model(32767, 32767, 12345, 1'b1));
    #1;
    in_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tp_valid", out_valid1, 1);
    e1 = q1.pop_front();
    chk("tp_alpha", i_alpha1, e1.al);
    chk("tp_beta", i_beta1, e1.be);
    chk("tp_sat", sat1, e1.s);
`ifdef CLARKE_SAT_EN
    chk("tp_beta_ref", i_beta1, 32767);
    chk("tp_sat_ref", sat1, 1);
`else
    chk("tp_beta_ref", i_beta1, -30783);
    chk("tp_sat_ref", sat1, 0);
`endif

    step();
    out_ready0 = 1'b0;
    bp_e = model(-12345, 20000, -7655, 1'b0);
    send0(-12345, 20000, -7655, 1'b0, t);
    wait_valid0(n);
    step();
    i_a0 = 16'sd999; i_b0 = 16'sd888; i_c0 = -16'sd777;
    in_valid0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid0, 1);
      chk("bp_in_ready", in_ready0, 0);
      chk("bp_alpha", i_alpha0, bp_e.al);
      chk("bp_beta", i_beta0, bp_e.be);
    end
    step();
    in_valid0 = 1'b0;
    out_ready0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_valid", out_valid0, 0);
    chk("bp_idle_ready", in_ready0, 1);
    wait_drain();

    step();
    send0(1000, 2000, -3000, 1'b0, t);
    step();
    rst_n = 1'b0;
    #1;
    q0.delete();
    chk("mid_rst_valid", out_valid0, 0);
    chk("mid_rst_ready", in_ready0, 0);
    chk("mid_rst_alpha", i_alpha0, 0);
    chk("mid_rst_beta", i_beta0, 0);
    chk("mid_rst_sat", sat0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
    send0(-5000, 3000, 7000, 1'b0, t);
    wait_drain();

    step();
    out_ready0 = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 8; i++) begin
      a = int'($urandom_range(65535)) - 32768;
      b = int'($urandom_range(65535)) - 32768;
      c = int'($urandom_range(65535)) - 32768;
      send0(a, b, c, 1'b1, t);
      if (i > 0) chk("b2b_gap", t - t_prev, 5);
      t_prev = t;
    end
    in_valid0 = 1'b0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
